// File: rtl/readout_pkg.sv
// Shared constants, state encoding and address helper for the channel readout sequencer.
package readout_pkg;

  localparam int NUM_CH    = 8;
  localparam int NUM_REG   = 7;
  localparam int BASE_ADDR = 11;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int TIMEOUT   = 16;
  localparam int CH_W      = $clog2(NUM_CH);
  localparam int REG_W     = 3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    REQ  = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } rdseq_state_e;

  // Evaluated at ADDR_W width; the top-level elaboration check guarantees no wrap.
  function automatic logic [ADDR_W-1:0] ch_reg_to_addr(input logic [CH_W-1:0]  ch_idx,
                                                       input logic [REG_W-1:0] reg_idx);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(NUM_REG) * ADDR_W'(ch_idx) + ADDR_W'(reg_idx);
  endfunction

endpackage

// File: rtl/ch_readout_sequencer_if.sv
// Register-bank read port plus the valid/ready output stream of the readout sequencer.
interface ch_readout_sequencer_if;
  import readout_pkg::*;

  // Read port: rd_addr/rd_sel are stable while rd_req=1; rd_ack/rd_data count only while rd_req=1.
  // Output stream: a word transfers on a rising edge with out_valid=1 and out_ready=1; until then
  // out_valid, out_data and out_addr hold their values.
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [REG_W-1:0]  rd_sel;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output rd_req, rd_addr, rd_sel, out_valid, out_data, out_addr,
    input  rd_ack, rd_data, out_ready
  );

  modport slave (
    input  rd_req, rd_addr, rd_sel, out_valid, out_data, out_addr,
    output rd_ack, rd_data, out_ready
  );

endinterface

// File: rtl/ch_reg_addr_gen.sv
// Channel/register walk counters with the absolute register address kept registered alongside.
module ch_reg_addr_gen
  import readout_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc_reg,
  input  logic              i_inc_ch,
  output logic [CH_W-1:0]   o_ch,
  output logic [REG_W-1:0]  o_reg,
  output logic [ADDR_W-1:0] o_addr
);

  logic [CH_W-1:0]   r_ch;
  logic [REG_W-1:0]  r_reg;
  logic [ADDR_W-1:0] r_addr;
  logic [CH_W-1:0]   w_ch_nxt;
  logic [REG_W-1:0]  w_reg_nxt;

  // Moving to the next channel always restarts at register 0.
  always_comb begin
    w_ch_nxt  = r_ch;
    w_reg_nxt = r_reg;
    if (i_clr) begin
      w_ch_nxt  = '0;
      w_reg_nxt = '0;
    end else if (i_inc_ch) begin
      w_ch_nxt  = r_ch + CH_W'(1);
      w_reg_nxt = '0;
    end else if (i_inc_reg) begin
      w_reg_nxt = r_reg + REG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch   <= '0;
      r_reg  <= '0;
      r_addr <= '0;
    end else if (i_clr || i_inc_ch || i_inc_reg) begin
      r_ch   <= w_ch_nxt;
      r_reg  <= w_reg_nxt;
      r_addr <= ch_reg_to_addr(w_ch_nxt, w_reg_nxt);
    end
  end

  assign o_ch   = r_ch;
  assign o_reg  = r_reg;
  assign o_addr = r_addr;

endmodule

// File: rtl/ch_readout_sequencer.sv
// Walks enabled channels/registers, reads each register with a timeout and streams the words out.
module ch_readout_sequencer
  import readout_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [NUM_CH-1:0]    i_ch_mask,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [2:0]           o_dbg_state,
  ch_readout_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_SCAN = SCAN;
  localparam logic [2:0] S_REQ  = REQ;
  localparam logic [2:0] S_OUT  = OUT;
  localparam logic [2:0] S_DONE = DONE;
  localparam int         TO_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  if (BASE_ADDR + NUM_CH * NUM_REG - 1 >= (1 << ADDR_W)) begin : g_addr_range_chk
    $error("register window does not fit in ADDR_W bits");
  end

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [NUM_CH-1:0] r_mask;
  logic [TO_W-1:0]   r_cnt;
  logic              r_err;
  logic [DATA_W-1:0] r_out_data;
  logic [ADDR_W-1:0] r_out_addr;

  logic              w_clr;
  logic              w_inc_reg;
  logic              w_inc_ch;
  logic [CH_W-1:0]   w_ch;
  logic [REG_W-1:0]  w_reg;
  logic [ADDR_W-1:0] w_addr;
  logic              w_ch_last;
  logic              w_reg_last;
  logic              w_timeout;

  ch_reg_addr_gen u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_inc_reg (w_inc_reg),
    .i_inc_ch  (w_inc_ch),
    .o_ch      (w_ch),
    .o_reg     (w_reg),
    .o_addr    (w_addr)
  );

  assign w_ch_last  = (w_ch == CH_W'(NUM_CH - 1));
  assign w_reg_last = (w_reg == REG_W'(NUM_REG - 1));
  assign w_timeout  = (r_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_inc_reg   = 1'b0;
    w_inc_ch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_clr       = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_mask[w_ch])   w_state_nxt = S_REQ;
        else if (!w_ch_last) w_inc_ch   = 1'b1;
        else                w_state_nxt = S_DONE;
      end
      S_REQ: begin
        if (bus.rd_ack || w_timeout) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          if (!w_reg_last) begin
            w_inc_reg   = 1'b1;
            w_state_nxt = S_REQ;
          end else if (w_ch_last) begin
            w_clr       = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_inc_ch    = 1'b1;
            w_state_nxt = S_SCAN;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mask     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && i_start) begin
        r_mask <= i_ch_mask;
        r_err  <= 1'b0;
      end
      // An ack on the final allowed cycle still wins over the timeout.
      if (r_state == S_REQ) begin
        if (bus.rd_ack) begin
          r_out_data <= bus.rd_data;
          r_out_addr <= w_addr;
          r_cnt      <= '0;
        end else if (w_timeout) begin
          r_out_data <= '1;
          r_out_addr <= w_addr;
          r_err      <= 1'b1;
          r_cnt      <= '0;
        end else begin
          r_cnt <= r_cnt + TO_W'(1);
        end
      end
    end
  end

  assign bus.rd_req    = (r_state == S_REQ);
  assign bus.rd_addr   = w_addr;
  assign bus.rd_sel    = w_reg;
  assign bus.out_valid = (r_state == S_OUT);
  assign bus.out_data  = r_out_data;
  assign bus.out_addr  = r_out_addr;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_err         = r_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ch_readout_sequencer.sv
// Directed bench for ch_readout_sequencer: register-bank model, stream scoreboard, timing checks.
module tb_ch_readout_sequencer;
  import readout_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] ch_mask;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] dbg_state;

  ch_readout_sequencer_if bus ();

  ch_readout_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .i_ch_mask   (ch_mask),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_dbg_state (dbg_state),
    .bus         (bus.master)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int ack_lat   = 1;
  int skip_addr = 127;
  int bank_cnt  = 0;
  int words, done_cnt, req_total, scan_cnt, req25;
  logic [14:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int a);
    if (a == skip_addr) return 8'hFF;
    return 8'(a) ^ 8'hA5;
  endfunction

  // ---------------- register bank model ----------------
  initial begin
    bus.rd_ack  = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.rd_req) begin
        bank_cnt++;
        bus.rd_ack = (bank_cnt > ack_lat) && (int'(bus.rd_addr) != skip_addr);
      end else begin
        bank_cnt   = 0;
        bus.rd_ack = 1'b0;
      end
      bus.rd_data = {1'b0, bus.rd_addr} ^ 8'hA5;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        words++;
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else check("word", {bus.out_addr, bus.out_data}, exp_q.pop_front());
      end
      if (bus.rd_req) begin
        req_total++;
        check("rd_sel", bus.rd_sel, (32'(bus.rd_addr) - 32'd11) % 32'd7);
        if (bus.rd_addr == 7'd25) req25++;
      end
      if (done) done_cnt++;
      if (dbg_state == 3'(SCAN)) scan_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic begin_scan(input logic [7:0] mask);
    for (int c = 0; c < 8; c++)
      if (mask[c])
        for (int r = 0; r < 7; r++) begin
          int a;
          a = 11 + 7 * c + r;
          exp_q.push_back({7'(a), exp_data(a)});
        end
    words = 0; done_cnt = 0; req_total = 0; scan_cnt = 0; req25 = 0;
    @(posedge clk); #1;
    start   = 1'b1;
    ch_mask = mask;
    @(posedge clk); #1;
    start   = 1'b0;
    ch_mask = ~mask;
  endtask

  task automatic finish_scan(input int n_words);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) check("done_seen", 0, 1);
    repeat (3) @(negedge clk);
    check("word_count", words, n_words);
    check("done_pulses", done_cnt, 1);
    check("queue_empty", exp_q.size(), 0);
    check("busy_after", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_for_req(input int a);
    bit seen;
    seen = 0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.rd_req && int'(bus.rd_addr) == a) seen = 1;
    end
    check("req_seen", seen, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; ch_mask = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rd_req", bus.rd_req, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_addr", bus.out_addr, 0);
    check("rst_state", dbg_state, 3'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // Full scan, ack one cycle after request.
    begin_scan(8'hFF);
    finish_scan(56);
    check("full_err", err, 0);

    // Sparse mask with zero-latency acks.
    ack_lat = 0;
    begin_scan(8'h81);
    finish_scan(14);
    check("sparse_scan_cycles", scan_cnt, 8);
    ack_lat = 1;

    // Empty mask: SCAN cycles 1..8, DONE at 9.
    begin_scan(8'h00);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("empty_state", dbg_state, (k < 9) ? 3'(SCAN) : 3'(DONE));
      check("empty_done", done, (k == 9));
    end
    finish_scan(0);
    check("empty_no_req", req_total, 0);

    // Timeout on address 25.
    skip_addr = 25;
    begin_scan(8'hFF);
    finish_scan(56);
    check("timeout_req_cycles", req25, 16);
    check("timeout_err_sticky", err, 1);
    skip_addr = 127;

    // Backpressure on address 40 with an ignored start.
    begin_scan(8'hFF);
    @(negedge clk);
    check("err_cleared", err, 0);
    wait_for_req(40);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 50 && !bus.out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_addr", bus.out_addr, 40);
      check("stall_data", bus.out_data, 8'h8D);
      check("stall_no_req", bus.rd_req, 0);
      @(posedge clk); #1;
      start = (i == 1);
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    finish_scan(56);

    // Reset while requesting address 33 (after a timeout at 12), then rescan.
    skip_addr = 12;
    begin_scan(8'hFF);
    wait_for_req(33);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rd_req", bus.rd_req, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_err", err, 0);
    exp_q.delete();
    skip_addr = 127;
    begin_scan(8'h01);
    finish_scan(7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ch_readout_sequencer.md
Name: ch_readout_sequencer

Overview:
Sequences SPI readback of the per-channel register file, address window 11..66 (NUM_CH channels × NUM_REG registers).
- Walks enabled channels and registers in order and issues one read request per register.
- Read address is addr = BASE_ADDR + NUM_REG*ch + reg; per-register select is reg (0..NUM_REG-1).
- Captures returned data, with a timeout, and streams it out with valid/ready.
- Sits between the SPI readout buffer and the channel register bank.

Parameters:
NUM_CH, 8, number of channels scanned
NUM_REG, 7, registers per channel
BASE_ADDR, 11, address of channel 0 register 0
ADDR_W, 7, address width
DATA_W, 8, register data width
TIMEOUT, 16, max cycles waiting for rd_ack (≥2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin scan, sampled in IDLE only
ch_mask  in  NUM_CH  channel enable, latched at start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at scan end
err  out  1  sticky, set on any timeout, cleared at accepted start
rd_req  out  1  read request to register bank
rd_addr  out  ADDR_W  absolute register address
rd_sel  out  3  register index within channel (0..NUM_REG-1)
rd_ack  in  1  bank response, valid only while rd_req=1
rd_data  in  DATA_W  read data, sampled when rd_ack=1
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  captured word
out_addr  out  ADDR_W  address the word came from

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, ch=0, reg=0, latched mask 0, timeout counter 0. rst wins over every other input.
- States: IDLE, SCAN, REQ, OUT, DONE.
- IDLE: start=1 latches ch_mask, sets ch=0, reg=0, clears err, moves to SCAN next cycle.
- SCAN, one cycle per channel:
  - mask[ch]=1 → REQ.
  - mask[ch]=0 and ch<NUM_CH-1 → ch++, stay in SCAN.
  - mask[ch]=0 and ch=NUM_CH-1 → DONE.
- REQ:
  - rd_req=1, with rd_addr and rd_sel registered and stable for the whole request.
  - Counter increments each cycle.
  - rd_ack=1 → out_data←rd_data, out_addr←rd_addr, clear counter, go OUT.
  - Counter reaches TIMEOUT-1 without ack → out_data←all ones, err←1, go OUT.
  - rd_req drops the cycle after ack or timeout.
  - An ack in the first REQ cycle is legal, giving 1-cycle latency.
- OUT:
  - out_valid=1; out_data and out_addr hold stable until out_valid&out_ready.
  - On accept with reg<NUM_REG-1 → reg++, go REQ.
  - On accept with reg=NUM_REG-1 → reg=0, then ch=NUM_CH-1 → DONE, else ch++ and go SCAN.
- DONE: done=1 for one cycle, then IDLE.
- start while busy is ignored. start high in the DONE cycle is also ignored; it is honoured only in IDLE.
- ch_mask changes after start have no effect on the running scan.
- rd_ack outside REQ is ignored.
- Address arithmetic is computed at ADDR_W width. The maximum address, 66, fits in 7 bits with no wrap. Elaboration checks BASE_ADDR+NUM_CH*NUM_REG-1 < 2^ADDR_W.
- Reset mid-scan: the cycle after rst, rd_req=0, out_valid=0, busy=0, err=0. Any pending word is discarded.

Decomposition:
- Package readout_pkg holds:
  - state enum rdseq_state_e {IDLE, SCAN, REQ, OUT, DONE};
  - constants NUM_CH, NUM_REG, BASE_ADDR, ADDR_W;
  - function ch_reg_to_addr(ch, reg).
- Sub-module ch_reg_addr_gen: registered ch/reg counters with increment and clear controls, plus the address output.
- FSM, timeout counter and output register stay in the top.

Test Plan:
- ch_mask=8'hFF, bank acks 1 cycle after rd_req, out_ready=1 → 56 words, out_addr 11,12,…,66 in order, rd_sel cycling 0..6, done pulses once, err=0.
- ch_mask=8'h81 → 14 words with addresses 11..17 then 60..66; six SCAN-skip cycles between them.
- ch_mask=8'h00, start at cycle 0 → SCAN cycles 1–8, done=1 at cycle 9, rd_req never asserted.
- No ack for address 25 (ch 2, reg 0), TIMEOUT=16 → rd_req high exactly 16 cycles, out_data=8'hFF, out_addr=25, err=1 sticky, scan continues to 26.
- out_ready low for 5 cycles on word at address 40 → out_valid, out_data and out_addr held stable, no rd_req in that window; a second start pulse in that window is ignored.
- rst asserted while rd_req=1 at address 33 → next cycle rd_req=0, busy=0, out_valid=0; a new start rescans from address 11.
